// File: rtl/tt_um_suhas1403_serial_subtractor.sv
// Bit-serial 8-bit subtractor: A - B computed LSB first through one full-subtractor cell
// with a registered borrow, using a start/busy/done handshake on the Tiny Tapeout pins.
module tt_um_suhas1403_serial_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t     state;
  logic [7:0] a_hold;
  logic [7:0] b_hold;
  logic [7:0] a_sh;
  logic [7:0] b_sh;
  logic [7:0] res_sh;
  logic       bw;
  logic [2:0] cnt;
  logic       start_q;
  logic       borrow;
  logic       zero;

  logic       load_a;
  logic       load_b;
  logic       start;
  logic       start_ev;
  logic       bit_a;
  logic       bit_b;
  logic       d;
  logic       bw_new;
  logic [7:0] res_next;
  logic       unused_uio;

  assign load_a     = uio_in[0];
  assign load_b     = uio_in[1];
  assign start      = uio_in[2];
  assign unused_uio = &{1'b0, uio_in[7:3]};

  assign start_ev = start & ~start_q;

  // Full-subtractor cell on the current LSBs.
  assign bit_a    = a_sh[0];
  assign bit_b    = b_sh[0];
  assign d        = bit_a ^ bit_b ^ bw;
  assign bw_new   = (~bit_a & bit_b) | (~bit_a & bw) | (bit_b & bw);
  assign res_next = {d, res_sh[7:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      a_hold  <= 8'h00;
      b_hold  <= 8'h00;
      a_sh    <= 8'h00;
      b_sh    <= 8'h00;
      res_sh  <= 8'h00;
      bw      <= 1'b0;
      cnt     <= 3'd0;
      start_q <= 1'b0;
      uo_out  <= 8'h00;
      borrow  <= 1'b0;
      zero    <= 1'b0;
    end else if (ena) begin
      start_q <= start;
      unique case (state)
        StIdle, StDone: begin
          if (load_a) a_hold <= ui_in;
          if (load_b) b_hold <= ui_in;
          // A load always wins over a coincident start; the edge is still consumed.
          if (load_a || load_b) begin
            state <= StIdle;
          end else if (start_ev) begin
            a_sh  <= a_hold;
            b_sh  <= b_hold;
            bw    <= 1'b0;
            cnt   <= 3'd0;
            state <= StRun;
          end
        end
        StRun: begin
          a_sh   <= {1'b0, a_sh[7:1]};
          b_sh   <= {1'b0, b_sh[7:1]};
          res_sh <= res_next;
          bw     <= bw_new;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            uo_out <= res_next;
            borrow <= bw_new;
            zero   <= (res_next == 8'h00);
            state  <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign uio_out = {1'b0, zero, borrow, (state == StDone), (state == StRun), 3'b000};
  assign uio_oe  = 8'b0111_1000;

endmodule

// File: tb/tb_tt_um_suhas1403_serial_subtractor.sv
// Scoreboard bench for the serial subtractor: stimulus pushes expected results, a monitor
// pops and compares them on each rising done.
module tb_tt_um_suhas1403_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_suhas1403_serial_subtractor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] diff;
    logic       bor;
    logic       zer;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ma = 8'h00;
  logic [7:0] mb = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain unsigned arithmetic on the latched operands.
  task automatic push(input int lat);
    exp_t e;
    int   diff;
    diff  = (int'(ma) - int'(mb)) & 255;
    e.diff = diff[7:0];
    e.bor  = (ma < mb);
    e.zer  = (diff == 0);
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic load(input logic [1:0] which, input logic [7:0] val);
    ui_in  = val;
    uio_in = {6'b0, which};
    tick();
    uio_in = 8'h00;
    if (which[0]) ma = val;
    if (which[1]) mb = val;
  endtask

  task automatic pulse_start();
    uio_in[2] = 1'b1;
    tick();
    uio_in[2] = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (uio_out[4]) break;
      tick();
    end
    if (!uio_out[4]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0b required=1", uio_out[4]);
    end
    tick();
  endtask

  task automatic op(input int lat);
    push(lat);
    pulse_start();
    wait_done();
  endtask

  // Monitor: busy run length and results checked at each rising done.
  int   bcnt = 0;
  logic pdone = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt  = 0;
      pdone = 1'b0;
    end else begin
      if (uio_out[4] && !pdone) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("diff", uo_out, e.diff);
          chk("borrow", uio_out[5], e.bor);
          chk("zero", uio_out[6], e.zer);
          chk("latency", bcnt, e.lat);
          chk("uio_oe", uio_oe, 8'h78);
          chk("uio_low_bits", {uio_out[7], uio_out[2:0]}, 4'h0);
        end
      end
      bcnt  = uio_out[3] ? bcnt + 1 : 0;
      pdone = uio_out[4];
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h78);
    rst_n = 1'b1;
    tick();

    load(2'b01, 8'h5A);
    load(2'b10, 8'h3C);
    op(8);
    chk("t1_diff", uo_out, 8'h1E);

    load(2'b01, 8'h10);
    load(2'b10, 8'h20);
    op(8);
    chk("t2_diff", uo_out, 8'hF0);
    chk("t2_borrow", uio_out[5], 1'b1);
    load(2'b01, 8'h00);
    load(2'b10, 8'h01);
    op(8);
    chk("t2b_diff", uo_out, 8'hFF);

    // Equal operands, start held high: exactly one operation.
    load(2'b01, 8'h77);
    load(2'b10, 8'h77);
    push(8);
    uio_in[2] = 1'b1;
    repeat (20) tick();
    chk("hold_done", uio_out[4], 1'b1);
    chk("hold_busy", uio_out[3], 1'b0);
    chk("hold_zero", uio_out[6], 1'b1);
    uio_in[2] = 1'b0;
    tick();

    // Load during RUN is ignored.
    load(2'b01, 8'hFF);
    load(2'b10, 8'h01);
    push(8);
    pulse_start();
    repeat (3) tick();
    ui_in  = 8'h00;
    uio_in = 8'h01;
    tick();
    uio_in = 8'h00;
    wait_done();
    chk("run_load_diff", uo_out, 8'hFE);

    // Reset mid-RUN aborts.
    pulse_start();
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_uo_out", uo_out, 8'h00);
    chk("abort_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    ma = 8'h00;
    mb = 8'h00;
    tick();

    // Restart from DONE without loads, then start with load_b is discarded.
    load(2'b01, 8'h5A);
    load(2'b10, 8'h3C);
    op(8);
    op(8);
    chk("rerun_diff", uo_out, 8'h1E);
    ui_in  = 8'h11;
    uio_in = 8'h06;
    tick();
    uio_in = 8'h00;
    mb = 8'h11;
    chk("discard_done", uio_out[4], 1'b0);
    chk("discard_busy", uio_out[3], 1'b0);
    repeat (3) tick();
    chk("discard_idle", uio_out[3], 1'b0);
    op(8);
    chk("newb_diff", uo_out, 8'h49);

    // ena low for 3 cycles in RUN stretches latency to 11.
    push(11);
    pulse_start();
    repeat (2) tick();
    ena = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    wait_done();

    for (int n = 0; n < 24; n++) begin
      logic [7:0] va;
      logic [7:0] vb;
      va = 8'($urandom);
      vb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        load(2'b11, va);
      end else begin
        load(2'b01, va);
        load(2'b10, vb);
      end
      op(8);
    end

    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
